param_sync_fifo: RTL and testbench

Parametrised single-clock valid/ready FIFO. It is the next generation of the team's synchronous FIFO and adds the following:
- configurable width and depth
- first-word-fall-through output
- full DEPTH capacity, with no sacrificed slot
- occupancy count and programmable almost-full / almost-empty flags
- synchronous flush
- high-water-mark monitor

It sits between streaming producer/consumer stages wherever rate decoupling or occupancy telemetry is needed.

---
 rtl/param_sync_fifo.sv | 106 ++++++++++
 tb/tb_param_sync_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock valid/ready FIFO with first-word-fall-through output, full DEPTH
// capacity, occupancy flags, synchronous flush and a high-water-mark monitor.
module param_sync_fifo #(
  parameter int WIDTH    = 33,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     upstr_d_valid,
  input  logic [WIDTH-1:0]         upstr_data,
  output logic                     upstr_d_ready,
  output logic                     downstr_d_valid,
  output logic [WIDTH-1:0]         downstr_data,
  input  logic                     downstr_d_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   hwm,
  input  logic                     clear_hwm
);

  localparam int   AW     = $clog2(DEPTH);
  localparam int   CW     = AW + 1;
  localparam logic AF_RST = (AF_LEVEL == 0) ? 1'b1 : 1'b0;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    fill_r;
  logic [CW-1:0]    hwm_r;
  logic             ready_r;
  logic             valid_r;
  logic             af_r;
  logic             ae_r;

  logic             wr_s;
  logic             rd_s;
  logic [CW-1:0]    fill_next_s;
  logic [CW-1:0]    hwm_next_s;

  // Handshake terms and next-state occupancy / high-water mark.
  always_comb begin
    wr_s        = upstr_d_valid & ready_r;
    rd_s        = valid_r & downstr_d_ready;
    fill_next_s = fill_r;
    hwm_next_s  = hwm_r;
    case ({wr_s, rd_s})
      2'b10:   fill_next_s = fill_r + CW'(1);
      2'b01:   fill_next_s = fill_r - CW'(1);
      default: fill_next_s = fill_r;
    endcase
    if (clear_hwm) begin
      hwm_next_s = fill_next_s;
    end else if (fill_next_s > hwm_r) begin
      hwm_next_s = fill_next_s;
    end else begin
      hwm_next_s = hwm_r;
    end
  end

  // Pointers, occupancy and registered status outputs; flush mirrors reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      fill_r   <= CW'(0);
      hwm_r    <= CW'(0);
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      af_r     <= AF_RST;
      ae_r     <= 1'b1;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      fill_r  <= fill_next_s;
      hwm_r   <= hwm_next_s;
      ready_r <= (fill_next_s != CW'(DEPTH));
      valid_r <= (fill_next_s != CW'(0));
      af_r    <= (fill_next_s >= CW'(AF_LEVEL));
      ae_r    <= (fill_next_s <= CW'(AE_LEVEL));
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_s && !rst && !flush) begin
      mem_r[wr_ptr_r] <= upstr_data;
    end
  end

  assign upstr_d_ready   = ready_r;
  assign downstr_d_valid = valid_r;
  assign downstr_data    = mem_r[rd_ptr_r];
  assign fill_level      = fill_r;
  assign almost_full     = af_r;
  assign almost_empty    = ae_r;
  assign hwm             = hwm_r;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at WIDTH=8, DEPTH=8,
// AF_LEVEL=6, AE_LEVEL=2.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       upstr_d_valid;
  logic [7:0] upstr_data;
  logic       upstr_d_ready;
  logic       downstr_d_valid;
  logic [7:0] downstr_data;
  logic       downstr_d_ready;
  logic [3:0] fill_level;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] hwm;
  logic       clear_hwm;

  int checks   = 0;
  int failures = 0;

  param_sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .upstr_d_valid(upstr_d_valid), .upstr_data(upstr_data), .upstr_d_ready(upstr_d_ready),
    .downstr_d_valid(downstr_d_valid), .downstr_data(downstr_data),
    .downstr_d_ready(downstr_d_ready), .fill_level(fill_level),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .hwm(hwm), .clear_hwm(clear_hwm)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle outputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; upstr_d_valid = 1'b0; upstr_data = 8'h00;
    downstr_d_ready = 1'b0; clear_hwm = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      upstr_d_valid = 1'b1; upstr_data = base + 8'(i);
      tick();
    end
    upstr_d_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    checks++; if (upstr_d_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", upstr_d_ready); end
    checks++; if (downstr_d_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", downstr_d_valid); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    checks++; if (hwm !== 4'd0) begin failures++; $display("FAIL reset_hwm got=%0d exp=0", hwm); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      upstr_d_valid = 1'b1; upstr_data = 8'(i);
      tick();
      checks++; if (fill_level !== 4'(i)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", fill_level, i); end
    end
    checks++; if (upstr_d_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", upstr_d_ready); end
    upstr_data = 8'h09;
    tick();
    upstr_d_valid = 1'b0;
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL overflow_fill got=%0d exp=8", fill_level); end
    downstr_d_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (downstr_d_valid !== 1'b1 || downstr_data !== 8'(i)) begin
        failures++; $display("FAIL drain_data got=%b/%0h exp=1/%0h", downstr_d_valid, downstr_data, i);
      end
      tick();
      checks++; if (fill_level !== 4'(8 - i)) begin failures++; $display("FAIL drain_fill got=%0d exp=%0d", fill_level, 8 - i); end
    end
    downstr_d_ready = 1'b0;
    checks++; if (downstr_d_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", downstr_d_valid); end
  endtask

  task automatic test_latency();
    do_reset();
    upstr_d_valid = 1'b1; upstr_data = 8'hA5;
    tick();
    upstr_d_valid = 1'b0;
    checks++;
    if (downstr_d_valid !== 1'b1 || downstr_data !== 8'hA5) begin
      failures++; $display("FAIL latency_fwft got=%b/%0h exp=1/a5", downstr_d_valid, downstr_data);
    end
    downstr_d_ready = 1'b1;
    tick();
    downstr_d_ready = 1'b0;
    checks++; if (downstr_d_valid !== 1'b0) begin failures++; $display("FAIL latency_drop got=%b exp=0", downstr_d_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    write_n(3, 8'd100);
    upstr_d_valid = 1'b1; downstr_d_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      upstr_data = 8'(103 + k);
      checks++; if (downstr_data !== 8'(100 + k)) begin failures++; $display("FAIL wrap_data got=%0d exp=%0d", downstr_data, 100 + k); end
      tick();
      checks++; if (fill_level !== 4'd3) begin failures++; $display("FAIL wrap_fill got=%0d exp=3", fill_level); end
    end
    upstr_d_valid = 1'b0;
    checks++; if (hwm !== 4'd3) begin failures++; $display("FAIL wrap_hwm got=%0d exp=3", hwm); end
    for (int k = 40; k < 43; k++) begin
      checks++; if (downstr_data !== 8'(100 + k)) begin failures++; $display("FAIL wrap_tail got=%0d exp=%0d", downstr_data, 100 + k); end
      tick();
    end
    downstr_d_ready = 1'b0;
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL wrap_empty got=%0d exp=0", fill_level); end
  endtask

  task automatic test_thresholds();
    logic [8:0] af_tab;
    logic [8:0] ae_tab;
    af_tab = 9'b111000000;
    ae_tab = 9'b000000111;
    do_reset();
    for (int f = 1; f <= 8; f++) begin
      upstr_d_valid = 1'b1; upstr_data = 8'(f);
      tick();
      upstr_d_valid = 1'b0;
      checks++;
      if (fill_level !== 4'(f) || almost_full !== af_tab[f] || almost_empty !== ae_tab[f]) begin
        failures++; $display("FAIL thr_up fill/af/ae got=%0d/%b/%b exp=%0d/%b/%b", fill_level, almost_full, almost_empty, f, af_tab[f], ae_tab[f]);
      end
    end
    for (int f = 7; f >= 0; f--) begin
      downstr_d_ready = 1'b1;
      tick();
      downstr_d_ready = 1'b0;
      checks++;
      if (fill_level !== 4'(f) || almost_full !== af_tab[f] || almost_empty !== ae_tab[f]) begin
        failures++; $display("FAIL thr_down fill/af/ae got=%0d/%b/%b exp=%0d/%b/%b", fill_level, almost_full, almost_empty, f, af_tab[f], ae_tab[f]);
      end
    end
  endtask

  task automatic test_flush_reset();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      write_n(5, 8'h10);
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      upstr_d_valid = 1'b1; upstr_data = 8'h77; downstr_d_ready = 1'b1;
      tick();
      idle_inputs(); rst = 1'b0;
      checks++;
      if (fill_level !== 4'd0 || downstr_d_valid !== 1'b0 || hwm !== 4'd0 || upstr_d_ready !== 1'b1 || almost_empty !== 1'b1) begin
        failures++; $display("FAIL clear_state pass=%0d fill/valid/hwm/ready/ae got=%0d/%b/%0d/%b/%b exp=0/0/0/1/1", pass, fill_level, downstr_d_valid, hwm, upstr_d_ready, almost_empty);
      end
      tick();
      checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL clear_hold pass=%0d got=%0d exp=0", pass, fill_level); end
      write_n(1, 8'h3C);
      checks++;
      if (downstr_d_valid !== 1'b1 || downstr_data !== 8'h3C) begin
        failures++; $display("FAIL clear_fresh pass=%0d got=%b/%0h exp=1/3c", pass, downstr_d_valid, downstr_data);
      end
      downstr_d_ready = 1'b1;
      tick();
      downstr_d_ready = 1'b0;
      checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL clear_read pass=%0d got=%0d exp=0", pass, fill_level); end
    end
  endtask

  task automatic test_hwm();
    do_reset();
    write_n(7, 8'h40);
    downstr_d_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    downstr_d_ready = 1'b0;
    checks++; if (fill_level !== 4'd2) begin failures++; $display("FAIL hwm_fill got=%0d exp=2", fill_level); end
    checks++; if (hwm !== 4'd7) begin failures++; $display("FAIL hwm_peak got=%0d exp=7", hwm); end
    clear_hwm = 1'b1;
    tick();
    clear_hwm = 1'b0;
    checks++; if (hwm !== 4'd2) begin failures++; $display("FAIL hwm_clear got=%0d exp=2", hwm); end
    write_n(1, 8'h50);
    checks++; if (hwm !== 4'd3) begin failures++; $display("FAIL hwm_rise got=%0d exp=3", hwm); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_fill_drain();
    test_latency();
    test_wrap();
    test_thresholds();
    test_flush_reset();
    test_hwm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
